rr_decode_arbiter4: RTL

//   Four-requester round-robin arbiter that sequences access to one shared

---
 rtl/rr_decode_arbiter4.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_decode_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time and one dead cycle
// between grants; the owner is carried as index+enable and decoded to a one-hot grant.
module rr_decode_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_en,
  output logic       busy,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner, arbitrating every cycle
  // GRANT | gnt_idx owns the resource, hold_cnt counts its cycles
  // GAP   | one dead cycle after a release, arbitrating for the next owner

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_idx_q, gnt_idx_d;
  logic          gnt_en_q, gnt_en_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Rotating priority scan starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_en_d   = gnt_en_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      S_IDLE, S_GAP: begin
        hold_cnt_d = '0;
        if (win_found) begin
          state_d   = S_GRANT;
          gnt_idx_d = win_idx;
          gnt_en_d  = 1'b1;
        end else begin
          state_d  = S_IDLE;
          gnt_en_d = 1'b0;
        end
      end
      S_GRANT: begin
        // A dropped request wins over the hold limit, so no timeout then.
        if (!req[gnt_idx_q]) begin
          state_d    = S_GAP;
          gnt_en_d   = 1'b0;
          ptr_d      = gnt_idx_q + 2'd1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_GAP;
          gnt_en_d   = 1'b0;
          timeout_d  = 1'b1;
          ptr_d      = gnt_idx_q + 2'd1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        gnt_en_d   = 1'b0;
        hold_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    gnt_d  = gnt_en_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_idx_q  <= 2'd0;
      gnt_en_q   <= 1'b0;
      gnt_q      <= 4'b0000;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_en_q   <= gnt_en_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_en  = gnt_en_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
